boa_cache_line_seq: RTL and testbench
=====================================

Name: boa_cache_line_seq

Overview:
Line transfer sequencer for the set-associative cache. It accepts one command at a time from the cache state machine: write back a dirty line, fill a line, or both in that order. It moves the line word by word between the cache data RAM and the external memory bus (boa_mem_bus, CPU side). It owns xm_bus for the whole transfer and reports completion with a one-cycle pulse.

Parameters:
alen, 24, number of address bits; word addresses are [alen-1:2].
line_size, 16, words per cache line; power of two, at least 2.
lines, 32, lines per way; power of two.
ways, 2, number of ways; power of two, at least 1.
lswidth (local), $clog2(line_size), word-in-line index width.
lwidth (local), $clog2(lines), line index width.
wwidth (local), max(1,$clog2(ways)), way index width.
tgrain (local), lswidth+2+lwidth, lowest address bit held in a tag.

Ports:
clk  in  1  CPU clock.
rst  in  1  Reset; synchronous, active-high.
cmd_valid  in  1  Command request.
cmd_ready  out  1  High only in IDLE; a command is accepted when cmd_valid && cmd_ready.
cmd_wb  in  1  Perform a writeback.
cmd_fill  in  1  Perform a fill, after the writeback if both are set.
cmd_way  in  wwidth  Target way.
cmd_line  in  lwidth  Target line index.
cmd_wb_tag  in  alen-tgrain  Address tag of the victim line.
cmd_fill_tag  in  alen-tgrain  Address tag of the line to fetch.
done  out  1  One-cycle pulse when the command finishes.
cr_re  out  1  Cache RAM read enable.
cr_addr  out  lwidth+lswidth  Cache RAM read address {line,word}.
cr_way  out  wwidth  Way selector for cr_rdata.
cr_rdata  in  32  Cache RAM read data, valid 1 cycle after cr_re.
cw_we  out  1  Cache RAM write strobe; full word.
cw_addr  out  lwidth+lswidth  Cache RAM write address {line,word}.
cw_way  out  wwidth  Way written.
cw_wdata  out  32  Cache RAM write data.
xm_bus  boa_mem_bus.CPU  -  External memory port: re, we[3:0], addr, wdata out; ready, rdata in.

Behaviour:
- Reset values: state IDLE; cmd_ready=1; done=0; cr_re=0; cw_we=0; xm_bus.re=0; xm_bus.we=0; all counters 0; address and data outputs 0.
- Reset mid-transfer aborts immediately: the next cycle is IDLE, all strobes are low, and no done pulse is issued.
- xm_bus protocol:
  - A request (re or we nonzero) is held stable until a cycle with ready=1; that cycle accepts it.
  - Read data is valid on xm_bus.rdata in the cycle after acceptance.
  - re and we are never asserted together.
- Accept in IDLE: latch way, line, both tags and both op bits.
  - cmd_wb=1 goes to WB_PRIME.
  - Otherwise cmd_fill=1 goes to FILL.
  - A command with neither bit set gives done one cycle later and returns to IDLE.
- WB_PRIME: assert cr_re for word 0, then go to WB.
- WB, word counter rc:
  - Drive we=4'hF, addr={wb_tag,line,rc}, wdata = RAM word.
  - On acceptance, rc increments and the RAM is read for rc+1.
  - A skid register holds cr_rdata while ready=0, so writes stream at one word per cycle when ready is held high.
  - After the word line_size-1 is accepted: go to FILL if cmd_fill, else DONE.
- FILL, issue counter ic and return counter rc:
  - re=1, addr={fill_tag,line,ic}; ic increments on each acceptance.
  - In the cycle after each acceptance: cw_we=1, cw_addr={line,rc}, cw_wdata=xm_bus.rdata, then rc increments.
  - ic stops at line_size; re drops once ic reaches line_size.
  - After the last write (rc wraps to 0): go to DONE.
- DONE: done=1 for one cycle, then IDLE. cmd_ready is therefore 0 for the whole transfer, including DONE.
- Counters are lswidth+1 bits wide so the line_size terminal value is detectable. Addresses are formed by concatenation, with no carry into the line index.
- Best-case latency with ready tied high:
  - Fill only: line_size+2 cycles from accept to done.
  - Writeback only: line_size+2.
  - Both: 2*line_size+3.

Decomposition:
- Package boa_cache_pkg holds:
  - the state enum (IDLE, WB_PRIME, WB, FILL, DONE);
  - a cache_cmd_t struct (wb, fill, way, line, wb_tag, fill_tag);
  - helper functions for word-address composition, shared with the cache controller.
- One sub-module: boa_skid_reg, a 32-bit hold register for RAM read data under back-pressure.

Test Plan:
- Fill only, line_size=16, ready tied high, fill_tag=0x15, line=3, way=1, memory word = address: cw_we for 16 consecutive cycles, cw_addr 0x30..0x3F, wdata 0x15_3_0..0x15_3_F pattern; done at cycle 18.
- Writeback only with RAM preloaded 0xA0000000+i, ready pattern 1,0,0,1 repeating: every word is written exactly once in order, with wdata stable during stalls; done after the 16th acceptance.
- Writeback+fill on the same line: all 16 writeback acceptances precede the first re; the fill returns new data; a single done pulse.
- Back-to-back commands with cmd_valid held high: cmd_ready=0 during the transfer; the second command is accepted the cycle after done.
- rst asserted during FILL word 7: strobes low next cycle, no done pulse, cmd_ready=1; a following fill completes correctly.
- Command with cmd_wb=0 and cmd_fill=0: no xm_bus or RAM activity; done one cycle after accept.

Source files
------------

// File: rtl/boa_cache_pkg.sv
// Shared definitions for the boa set-associative cache.
// Holds the cache geometry, the line-sequencer state encoding, the
// command record passed from the cache controller to the line sequencer,
// and the address composition helpers that both blocks use.
package boa_cache_pkg;

  // Cache geometry. The line sequencer's parameters default to these values.
  // The command record below is sized from them, so an instance must keep
  // the same geometry.
  localparam int BOA_ALEN      = 24;
  localparam int BOA_LINE_SIZE = 16;
  localparam int BOA_LINES     = 32;
  localparam int BOA_WAYS      = 2;

  localparam int BOA_LSWIDTH = $clog2(BOA_LINE_SIZE);
  localparam int BOA_LWIDTH  = $clog2(BOA_LINES);
  localparam int BOA_WWIDTH  = (BOA_WAYS > 1) ? $clog2(BOA_WAYS) : 1;
  localparam int BOA_TGRAIN  = BOA_LSWIDTH + 2 + BOA_LWIDTH;
  localparam int BOA_TWIDTH  = BOA_ALEN - BOA_TGRAIN;

  typedef logic [BOA_TWIDTH-1:0]             tag_t;
  typedef logic [BOA_LWIDTH-1:0]             line_idx_t;
  typedef logic [BOA_LSWIDTH-1:0]            word_idx_t;
  typedef logic [BOA_WWIDTH-1:0]             way_t;
  typedef logic [BOA_LWIDTH+BOA_LSWIDTH-1:0] ram_addr_t;
  typedef logic [BOA_ALEN-1:2]               mem_waddr_t;

  typedef enum logic [2:0] {
    IDLE,
    WB_PRIME,
    WB,
    FILL,
    DONE
  } seq_state_e;

  typedef struct packed {
    logic      wb;
    logic      fill;
    way_t      way;
    line_idx_t line;
    tag_t      wb_tag;
    tag_t      fill_tag;
  } cache_cmd_t;

  // External word address of one word of a line: {tag, line, word}.
  function automatic mem_waddr_t mem_word_addr(input tag_t tag, input line_idx_t line,
                                               input word_idx_t word);
    return {tag, line, word};
  endfunction

  // Cache data RAM address of one word of a line: {line, word}.
  function automatic ram_addr_t ram_word_addr(input line_idx_t line, input word_idx_t word);
    return {line, word};
  endfunction

endpackage

// File: rtl/boa_mem_bus.sv
// CPU-side external memory bus.
//   re     : read request
//   we     : byte write strobes, never together with re
//   addr   : word address [alen-1:2]
//   wdata  : write data
//   ready  : accepts the request held in the same cycle
//   rdata  : read data, valid the cycle after a read is accepted
interface boa_mem_bus #(
  parameter int alen = 24
);
  logic              re;
  logic [3:0]        we;
  logic [alen-1:2]   addr;
  logic [31:0]       wdata;
  logic              ready;
  logic [31:0]       rdata;

  modport CPU (output re, output we, output addr, output wdata,
               input ready, input rdata);
  modport MEM (input re, input we, input addr, input wdata,
               output ready, output rdata);
endinterface

// File: rtl/boa_skid_reg.sv
// Hold register for cache RAM read data under bus back-pressure.
// The RAM presents a word only in the cycle after it was read; when the
// bus stalls the write, this register keeps that word so it can be
// re-presented until the bus accepts it.
//   clk, rst : clock, synchronous active-high reset
//   load_i   : d_i carries fresh RAM data this cycle
//   d_i      : RAM read data
//   q_o      : fresh data when load_i, otherwise the held word
module boa_skid_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (load_i) begin
      hold_q <= d_i;
    end
  end

  assign q_o = load_i ? d_i : hold_q;

endmodule

// File: rtl/boa_cache_line_seq.sv
// Line transfer sequencer for the set-associative cache.
// Takes one command at a time (writeback, fill, or writeback then fill) and
// moves a whole line word by word between the cache data RAM and the
// external memory bus, pulsing done for one cycle when finished.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake, ready only in IDLE
//   cmd_wb, cmd_fill      : requested operations
//   cmd_way, cmd_line     : target way and line index
//   cmd_wb_tag            : tag of the victim line
//   cmd_fill_tag          : tag of the line to fetch
//   done                  : one-cycle completion pulse
//   cr_re/cr_addr/cr_way  : cache RAM read port, cr_rdata one cycle later
//   cw_we/cw_addr/cw_way/cw_wdata : cache RAM write port
//   xm_bus                : external memory bus, CPU side
module boa_cache_line_seq
  import boa_cache_pkg::*;
#(
  parameter int alen      = BOA_ALEN,
  parameter int line_size = BOA_LINE_SIZE,
  parameter int lines     = BOA_LINES,
  parameter int ways      = BOA_WAYS,
  localparam int lswidth  = $clog2(line_size),
  localparam int lwidth   = $clog2(lines),
  localparam int wwidth   = (ways > 1) ? $clog2(ways) : 1,
  localparam int tgrain   = lswidth + 2 + lwidth
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_wb,
  input  logic                      cmd_fill,
  input  logic [wwidth-1:0]         cmd_way,
  input  logic [lwidth-1:0]         cmd_line,
  input  logic [alen-tgrain-1:0]    cmd_wb_tag,
  input  logic [alen-tgrain-1:0]    cmd_fill_tag,
  output logic                      done,
  output logic                      cr_re,
  output logic [lwidth+lswidth-1:0] cr_addr,
  output logic [wwidth-1:0]         cr_way,
  input  logic [31:0]               cr_rdata,
  output logic                      cw_we,
  output logic [lwidth+lswidth-1:0] cw_addr,
  output logic [wwidth-1:0]         cw_way,
  output logic [31:0]               cw_wdata,
  boa_mem_bus.CPU                   xm_bus
);

  // Counters carry one extra bit so the issue counter can sit at line_size.
  localparam int CNT_W = lswidth + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(line_size - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(line_size);

  seq_state_e       state_q, state_d;
  cache_cmd_t       cmd_q, cmd_d;
  logic [CNT_W-1:0] rc_q, rc_d;     // writeback word / fill return word
  logic [CNT_W-1:0] ic_q, ic_d;     // fill issue word
  logic             rd_fresh_q;     // cr_rdata carries a new word this cycle
  logic             fill_pend_q, fill_pend_d;  // xm_bus.rdata valid this cycle
  logic [31:0]      wb_word;

  boa_skid_reg u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (rd_fresh_q),
    .d_i    (cr_rdata),
    .q_o    (wb_word)
  );

  assign cr_way = cmd_q.way;
  assign cw_way = cmd_q.way;

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    rc_d          = rc_q;
    ic_d          = ic_q;
    fill_pend_d   = 1'b0;
    cmd_ready     = 1'b0;
    done          = 1'b0;
    cr_re         = 1'b0;
    cr_addr       = '0;
    cw_we         = 1'b0;
    cw_addr       = '0;
    cw_wdata      = '0;
    xm_bus.re     = 1'b0;
    xm_bus.we     = 4'h0;
    xm_bus.addr   = '0;
    xm_bus.wdata  = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        rc_d      = '0;
        ic_d      = '0;
        if (cmd_valid) begin
          cmd_d.wb       = cmd_wb;
          cmd_d.fill     = cmd_fill;
          cmd_d.way      = cmd_way;
          cmd_d.line     = cmd_line;
          cmd_d.wb_tag   = cmd_wb_tag;
          cmd_d.fill_tag = cmd_fill_tag;
          if (cmd_wb)        state_d = WB_PRIME;
          else if (cmd_fill) state_d = FILL;
          else               state_d = DONE;
        end
      end

      WB_PRIME: begin
        cr_re   = 1'b1;
        cr_addr = ram_word_addr(cmd_q.line, '0);
        state_d = WB;
      end

      WB: begin
        xm_bus.we    = 4'hF;
        xm_bus.addr  = mem_word_addr(cmd_q.wb_tag, cmd_q.line, rc_q[lswidth-1:0]);
        xm_bus.wdata = wb_word;
        if (xm_bus.ready) begin
          if (rc_q == CNT_LAST) begin
            rc_d    = '0;
            state_d = cmd_q.fill ? FILL : DONE;
          end else begin
            // Read ahead so the next word is on cr_rdata next cycle.
            rc_d    = rc_q + 1'b1;
            cr_re   = 1'b1;
            cr_addr = ram_word_addr(cmd_q.line, rc_d[lswidth-1:0]);
          end
        end
      end

      FILL: begin
        if (ic_q != CNT_FULL) begin
          xm_bus.re   = 1'b1;
          xm_bus.addr = mem_word_addr(cmd_q.fill_tag, cmd_q.line, ic_q[lswidth-1:0]);
          if (xm_bus.ready) begin
            ic_d        = ic_q + 1'b1;
            fill_pend_d = 1'b1;
          end
        end
        if (fill_pend_q) begin
          cw_we    = 1'b1;
          cw_addr  = ram_word_addr(cmd_q.line, rc_q[lswidth-1:0]);
          cw_wdata = xm_bus.rdata;
          if (rc_q == CNT_LAST) begin
            rc_d    = '0;
            ic_d    = '0;
            state_d = DONE;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rc_q        <= '0;
      ic_q        <= '0;
      rd_fresh_q  <= 1'b0;
      fill_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rc_q        <= rc_d;
      ic_q        <= ic_d;
      rd_fresh_q  <= cr_re;
      fill_pend_q <= fill_pend_d;
    end
  end

endmodule

// File: tb/tb_boa_cache_line_seq.sv
module tb_boa_cache_line_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wb, cmd_fill;
  logic [0:0]  cmd_way;
  logic [4:0]  cmd_line;
  logic [12:0] cmd_wb_tag, cmd_fill_tag;
  logic        done;
  logic        cr_re;
  logic [8:0]  cr_addr;
  logic [0:0]  cr_way;
  logic [31:0] cr_rdata;
  logic        cw_we;
  logic [8:0]  cw_addr;
  logic [0:0]  cw_way;
  logic [31:0] cw_wdata;

  boa_mem_bus #(.alen(24)) xm();

  boa_cache_line_seq dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_wb       (cmd_wb),
    .cmd_fill     (cmd_fill),
    .cmd_way      (cmd_way),
    .cmd_line     (cmd_line),
    .cmd_wb_tag   (cmd_wb_tag),
    .cmd_fill_tag (cmd_fill_tag),
    .done         (done),
    .cr_re        (cr_re),
    .cr_addr      (cr_addr),
    .cr_way       (cr_way),
    .cr_rdata     (cr_rdata),
    .cw_we        (cw_we),
    .cw_addr      (cw_addr),
    .cw_way       (cw_way),
    .cw_wdata     (cw_wdata),
    .xm_bus       (xm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- cache RAM model (registered read) ----------------
  logic [31:0] ram_m [0:1][0:511];
  logic [31:0] ram_rd_q = '0;
  logic        pl_go = 1'b0;
  logic        pl_way = 1'b0;
  logic [4:0]  pl_line = '0;
  logic [31:0] pl_base = '0;

  always @(posedge clk) begin
    if (pl_go)
      for (int i = 0; i < 16; i++) ram_m[pl_way][{pl_line, 4'(i)}] <= pl_base + 32'(i);
    if (cw_we) ram_m[cw_way][cw_addr] <= cw_wdata;
    if (cr_re) ram_rd_q <= ram_m[cr_way][cr_addr];
  end
  assign cr_rdata = ram_rd_q;

  // ---------------- external memory model ----------------
  logic [31:0] mem_salt = '0;
  logic [31:0] mem_rd_q = '0;
  int          ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1

  function automatic logic [31:0] mem_val(input logic [21:0] a, input logic [31:0] salt);
    return 32'(a) ^ salt;
  endfunction

  always @(posedge clk) if (xm.re && xm.ready) mem_rd_q <= mem_val(xm.addr, mem_salt);
  assign xm.rdata = mem_rd_q;

  initial begin
    int ph;
    ph = 0;
    xm.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) xm.ready = 1'b1;
      else                 xm.ready = (ph % 4 == 0) || (ph % 4 == 3);
      ph++;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [21:0] addr; logic [31:0] data; } memw_t;
  typedef struct packed { logic way; logic [8:0] addr; logic [31:0] data; } cww_t;
  memw_t exp_mem_q[$];
  cww_t  exp_cw_q[$];

  int done_cnt = 0, last_done_cyc = -1, act_cnt = 0, cw_cnt = 0;
  int last_wb_acc_cyc = -1, first_re_cyc = -1;
  int last_acc = -1, last_dcyc = -1;

  task automatic push_wb(input logic [12:0] tag, input logic [4:0] line, input logic [31:0] base);
    memw_t m;
    for (int i = 0; i < 16; i++) begin
      m.addr = {tag, line, 4'(i)};
      m.data = base + 32'(i);
      exp_mem_q.push_back(m);
    end
  endtask

  task automatic push_fill(input logic way, input logic [12:0] tag, input logic [4:0] line);
    cww_t c;
    for (int i = 0; i < 16; i++) begin
      c.way  = way;
      c.addr = {line, 4'(i)};
      c.data = mem_val({tag, line, 4'(i)}, mem_salt);
      exp_cw_q.push_back(c);
    end
  endtask

  // Monitor: samples DUT outputs mid-cycle, pops and compares expectations.
  initial begin
    logic        hold_v;
    logic [21:0] hold_addr;
    logic [31:0] hold_data;
    memw_t       em;
    cww_t        ec;
    hold_v = 1'b0;
    hold_addr = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (cr_re || cw_we || xm.re || (xm.we != 4'h0)) act_cnt++;
      if (xm.re || (xm.we != 4'h0))
        check_val("re_we_excl", 64'(xm.re && (xm.we != 4'h0)), 64'd0);
      if (xm.re && first_re_cyc < 0) first_re_cyc = cyc;
      if (xm.we != 4'h0) begin
        if (hold_v) begin
          check_val("wb_hold_addr", 64'(xm.addr), 64'(hold_addr));
          check_val("wb_hold_data", 64'(xm.wdata), 64'(hold_data));
        end
        if (xm.ready) begin
          check_val("wb_expected", 64'(exp_mem_q.size() != 0), 64'd1);
          if (exp_mem_q.size() != 0) begin
            em = exp_mem_q.pop_front();
            check_val("wb_strobe", 64'(xm.we), 64'hF);
            check_val("wb_addr", 64'(xm.addr), 64'(em.addr));
            check_val("wb_data", 64'(xm.wdata), 64'(em.data));
          end
          last_wb_acc_cyc = cyc;
          hold_v = 1'b0;
        end else begin
          hold_v    = 1'b1;
          hold_addr = xm.addr;
          hold_data = xm.wdata;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (cw_we) begin
        cw_cnt++;
        check_val("cw_expected", 64'(exp_cw_q.size() != 0), 64'd1);
        if (exp_cw_q.size() != 0) begin
          ec = exp_cw_q.pop_front();
          check_val("cw_way", 64'(cw_way), 64'(ec.way));
          check_val("cw_addr", 64'(cw_addr), 64'(ec.addr));
          check_val("cw_data", 64'(cw_wdata), 64'(ec.data));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic wb, input logic fill, input logic way, input logic [4:0] line,
                           input logic [12:0] wbtag, input logic [12:0] filltag);
    @(posedge clk);
    #1;
    cmd_valid    = 1'b1;
    cmd_wb       = wb;
    cmd_fill     = fill;
    cmd_way      = way;
    cmd_line     = line;
    cmd_wb_tag   = wbtag;
    cmd_fill_tag = filltag;
  endtask

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    check_val("cmd_accepted", 64'(acc >= 0), 64'd1);
  endtask

  task automatic wait_done(input int start_cnt, output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 200; k++) begin
      if (done_cnt > start_cnt) begin
        dcyc = last_done_cyc;
        break;
      end
      tick();
    end
    check_val("done_seen", 64'(dcyc >= 0), 64'd1);
  endtask

  task automatic preload(input logic way, input logic [4:0] line, input logic [31:0] base);
    @(posedge clk);
    #1;
    pl_way  = way;
    pl_line = line;
    pl_base = base;
    pl_go   = 1'b1;
    @(posedge clk);
    #1;
    pl_go = 1'b0;
  endtask

  task automatic run_cmd(input logic wb, input logic fill, input logic way, input logic [4:0] line,
                         input logic [12:0] wbtag, input logic [12:0] filltag, input int exp_lat);
    int acc, dcyc, d0;
    d0 = done_cnt;
    drive_cmd(wb, fill, way, line, wbtag, filltag);
    wait_accept(acc);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(d0, dcyc);
    if (exp_lat >= 0) check_val("latency", 64'(dcyc - acc), 64'(exp_lat));
    check_val("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    check_val("cw_q_drained", 64'(exp_cw_q.size()), 64'd0);
    $display("cmd wb=%0b fill=%0b way=%0d line=%0d accept@%0d done@%0d", wb, fill, way, line, acc, dcyc);
    last_acc  = acc;
    last_dcyc = dcyc;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- test sequence ----------------
  initial begin
    int acc_a, acc_b, d_a, d_b, d0, c0, a0;
    memw_t m;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_wb = 1'b0;
    cmd_fill = 1'b0;
    cmd_way = '0;
    cmd_line = '0;
    cmd_wb_tag = '0;
    cmd_fill_tag = '0;

    repeat (3) @(posedge clk);
    tick();
    check_val("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_cr_re", 64'(cr_re), 64'd0);
    check_val("rst_cw_we", 64'(cw_we), 64'd0);
    check_val("rst_xm_re", 64'(xm.re), 64'd0);
    check_val("rst_xm_we", 64'(xm.we), 64'd0);
    check_val("rst_xm_addr", 64'(xm.addr), 64'd0);
    check_val("rst_xm_wdata", 64'(xm.wdata), 64'd0);
    check_val("rst_cr_addr", 64'(cr_addr), 64'd0);
    check_val("rst_cw_addr", 64'(cw_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill only, ready high: 16 writes then done 18 cycles after accept.
    push_fill(1'b1, 13'h015, 5'd3);
    run_cmd(1'b0, 1'b1, 1'b1, 5'd3, 13'h000, 13'h015, 18);

    // Writeback only under a 1,0,0,1 ready pattern.
    preload(1'b0, 5'd5, 32'hA000_0000);
    ready_mode = 1;
    push_wb(13'h0A5, 5'd5, 32'hA000_0000);
    run_cmd(1'b1, 1'b0, 1'b0, 5'd5, 13'h0A5, 13'h000, -1);
    check_val("wb_done_after_last", 64'(last_dcyc), 64'(last_wb_acc_cyc + 1));
    ready_mode = 0;

    // Writeback then fill of the same line.
    preload(1'b1, 5'd7, 32'hB000_0000);
    mem_salt = 32'h5A5A_0000;
    push_wb(13'h101, 5'd7, 32'hB000_0000);
    push_fill(1'b1, 13'h055, 5'd7);
    first_re_cyc = -1;
    d0 = done_cnt;
    run_cmd(1'b1, 1'b1, 1'b1, 5'd7, 13'h101, 13'h055, 35);
    check_val("wb_before_fill", 64'(last_wb_acc_cyc < first_re_cyc), 64'd1);
    repeat (3) tick();
    check_val("single_done", 64'(done_cnt), 64'(d0 + 1));
    mem_salt = '0;

    // Back-to-back with cmd_valid held: fill line 1, then write it back.
    push_fill(1'b0, 13'h020, 5'd1);
    for (int i = 0; i < 16; i++) begin
      m.addr = {13'h033, 5'd1, 4'(i)};
      m.data = mem_val({13'h020, 5'd1, 4'(i)}, mem_salt);
      exp_mem_q.push_back(m);
    end
    d0 = done_cnt;
    drive_cmd(1'b0, 1'b1, 1'b0, 5'd1, 13'h000, 13'h020);
    wait_accept(acc_a);
    @(posedge clk);
    #1;
    cmd_wb = 1'b1;
    cmd_fill = 1'b0;
    cmd_wb_tag = 13'h033;
    cmd_fill_tag = 13'h000;
    d_a = -1;
    for (int k = 0; k < 200; k++) begin
      tick();
      check_val("b2b_ready_low", 64'(cmd_ready), 64'd0);
      if (done_cnt > d0) begin
        d_a = last_done_cyc;
        break;
      end
    end
    check_val("b2b_latency_a", 64'(d_a - acc_a), 64'd18);
    tick();
    check_val("b2b_accept_b", 64'(cmd_ready), 64'd1);
    acc_b = cyc;
    check_val("b2b_accept_cycle", 64'(acc_b), 64'(d_a + 1));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(d0 + 1, d_b);
    check_val("b2b_latency_b", 64'(d_b - acc_b), 64'd18);
    check_val("b2b_mem_q", 64'(exp_mem_q.size()), 64'd0);
    check_val("b2b_cw_q", 64'(exp_cw_q.size()), 64'd0);
    $display("cmd b2b fill then wb line=1 accept@%0d/%0d done@%0d/%0d", acc_a, acc_b, d_a, d_b);

    // Reset in the middle of a fill, then a clean fill of the same line.
    push_fill(1'b1, 13'h00C, 5'd9);
    c0 = cw_cnt;
    d0 = done_cnt;
    drive_cmd(1'b0, 1'b1, 1'b1, 5'd9, 13'h000, 13'h00C);
    wait_accept(acc_a);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (cw_cnt - c0 >= 7) break;
      tick();
    end
    check_val("abort_reached_word7", 64'(cw_cnt - c0), 64'd7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check_val("abort_xm_re", 64'(xm.re), 64'd0);
    check_val("abort_xm_we", 64'(xm.we), 64'd0);
    check_val("abort_cw_we", 64'(cw_we), 64'd0);
    check_val("abort_cr_re", 64'(cr_re), 64'd0);
    check_val("abort_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_cw_q.delete();
    repeat (3) tick();
    check_val("abort_no_done", 64'(done_cnt), 64'(d0));
    $display("cmd fill line=9 aborted by reset accept@%0d", acc_a);
    push_fill(1'b1, 13'h00D, 5'd9);
    run_cmd(1'b0, 1'b1, 1'b1, 5'd9, 13'h000, 13'h00D, 18);

    // Command with no operation: no bus or RAM activity, done next cycle.
    a0 = act_cnt;
    run_cmd(1'b0, 1'b0, 1'b0, 5'd2, 13'h1FF, 13'h1FF, 1);
    check_val("noop_activity", 64'(act_cnt - a0), 64'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
